// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the rv32i memory/writeback stage
package rv32i_pkg;

    localparam int DPW = 32;
    localparam int RDW = 5;

    localparam logic RES_ALU = 1'b0;
    localparam logic RES_MEM = 1'b1;

    typedef struct packed {
        logic           regwrite;
        logic           resultsrc;
        logic [DPW-1:0] aluresult;
        logic [DPW-1:0] readdata;
        logic [RDW-1:0] rd;
    } memwb_t;

    // Saturating 16-bit increment used by the optional event counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/rv32i_dmem.sv
// rtl/rv32i_dmem.sv - single-port word-wide data memory, synchronous write, asynchronous read
module rv32i_dmem
    import rv32i_pkg::*;
#(
    parameter int DMEM_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(DMEM_DEPTH)-1:0] addr,
    input  logic [DPW-1:0]                wdata,
    output logic [DPW-1:0]                rdata
);

    logic [DPW-1:0] mem_q [DMEM_DEPTH];

    // Word write on the clock edge; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Combinational read so a store is visible to a load on the next cycle.
    always_comb begin
        rdata = mem_q[addr];
    end

endmodule

// File: rtl/rv32i_mem_wb.sv
// rtl/rv32i_mem_wb.sv - rv32i memory-access and writeback stage (optional RV32I_MEMWB_PERF_EN counters)
module rv32i_mem_wb
    import rv32i_pkg::*;
#(
    parameter int ADW        = 5,
    parameter int DMEM_DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [ADW-1:0] RdM,
    input  logic           stallW,
    input  logic           flushW,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3,
    output logic           we,
    output logic           fwd_valid,
`ifdef RV32I_MEMWB_PERF_EN
    output logic [15:0]    load_cnt,
    output logic [15:0]    store_cnt,
    output logic [15:0]    misalign_cnt,
`endif
    output logic           misaligned
);

    localparam int IW = $clog2(DMEM_DEPTH);

    logic [IW-1:0]  word_idx;
    logic           addr_misaligned;
    logic           store_en;
    logic [DPW-1:0] dmem_rdata;
    logic [DPW-1:0] load_data;
    logic           unused_upper_addr;

    memwb_t memwb_d, memwb_q;
    logic   misaligned_d, misaligned_q;

    // Address decode: upper bits fold away so addresses wrap on the memory size.
    always_comb begin
        word_idx          = aluresultM[IW+1:2];
        addr_misaligned   = |aluresultM[1:0];
        store_en          = memwriteM && !addr_misaligned && !stallW && rst_n;
        load_data         = addr_misaligned ? '0 : dmem_rdata;
        unused_upper_addr = ^aluresultM[DPW-1:IW+2];
    end

    rv32i_dmem #(
        .DMEM_DEPTH(DMEM_DEPTH)
    ) u_dmem (
        .clk  (clk),
        .we   (store_en),
        .addr (word_idx),
        .wdata(Rd2M),
        .rdata(dmem_rdata)
    );

    // MEM/WB next state: flush bubbles the control fields and beats stall.
    always_comb begin
        memwb_d = memwb_q;
        if (flushW) begin
            memwb_d.regwrite  = 1'b0;
            memwb_d.resultsrc = RES_ALU;
            memwb_d.rd        = '0;
        end else if (!stallW) begin
            memwb_d.regwrite  = regwriteM;
            memwb_d.resultsrc = resultsrcM;
            memwb_d.aluresult = aluresultM;
            memwb_d.readdata  = load_data;
            memwb_d.rd        = RdM;
        end
    end

    // Sticky flag for any misaligned load or store seen since reset.
    always_comb begin
        misaligned_d = misaligned_q
                     | (addr_misaligned && (memwriteM || (resultsrcM == RES_MEM)));
    end

    // Pipeline register and sticky flag, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            memwb_q      <= memwb_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Writeback mux and register-file port; x0 is never written.
    always_comb begin
        addr_3     = memwb_q.rd;
        wd_3       = (memwb_q.resultsrc == RES_MEM) ? memwb_q.readdata : memwb_q.aluresult;
        we         = memwb_q.regwrite && (memwb_q.rd != '0);
        fwd_valid  = we;
        misaligned = misaligned_q;
    end

`ifdef RV32I_MEMWB_PERF_EN
    logic        advance;
    logic        load_evt;
    logic        store_evt;
    logic        mis_evt;
    logic [15:0] load_cnt_d, load_cnt_q;
    logic [15:0] store_cnt_d, store_cnt_q;
    logic [15:0] misalign_cnt_d, misalign_cnt_q;

    // Event qualification: stalled or flushed slots are not counted.
    always_comb begin
        advance        = !stallW && !flushW;
        load_evt       = advance && (resultsrcM == RES_MEM) && !addr_misaligned;
        store_evt      = advance && memwriteM && !addr_misaligned;
        mis_evt        = advance && addr_misaligned && (memwriteM || (resultsrcM == RES_MEM));
        load_cnt_d     = sat_inc(load_cnt_q, load_evt);
        store_cnt_d    = sat_inc(store_cnt_q, store_evt);
        misalign_cnt_d = sat_inc(misalign_cnt_q, mis_evt);
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q     <= '0;
            store_cnt_q    <= '0;
            misalign_cnt_q <= '0;
        end else begin
            load_cnt_q     <= load_cnt_d;
            store_cnt_q    <= store_cnt_d;
            misalign_cnt_q <= misalign_cnt_d;
        end
    end

    // Counter outputs.
    always_comb begin
        load_cnt     = load_cnt_q;
        store_cnt    = store_cnt_q;
        misalign_cnt = misalign_cnt_q;
    end
`endif

endmodule

// File: tb/tb_rv32i_mem_wb.sv
// tb/tb_rv32i_mem_wb.sv - directed table-driven bench for rv32i_mem_wb
module tb_rv32i_mem_wb;
    import rv32i_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           regwriteM;
    logic           resultsrcM;
    logic           memwriteM;
    logic [DPW-1:0] aluresultM;
    logic [DPW-1:0] Rd2M;
    logic [4:0]     RdM;
    logic           stallW;
    logic           flushW;
    logic [4:0]     addr_3;
    logic [DPW-1:0] wd_3;
    logic           we;
    logic           fwd_valid;
    logic           misaligned;

    int n_pass;
    int n_total;

    rv32i_mem_wb #(
        .ADW(5),
        .DMEM_DEPTH(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regwriteM (regwriteM),
        .resultsrcM(resultsrcM),
        .memwriteM (memwriteM),
        .aluresultM(aluresultM),
        .Rd2M      (Rd2M),
        .RdM       (RdM),
        .stallW    (stallW),
        .flushW    (flushW),
        .addr_3    (addr_3),
        .wd_3      (wd_3),
        .we        (we),
        .fwd_valid (fwd_valid),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic        stall;
        logic        flush;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
        logic        chk_wd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic rs, input logic mw, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] rd, input logic st, input logic fl);
        regwriteM  = rw;
        resultsrcM = rs;
        memwriteM  = mw;
        aluresultM = alu;
        Rd2M       = rd2;
        RdM        = rd;
        stallW     = st;
        flushW     = fl;
    endtask

    task automatic cycle(input logic rw, input logic rs, input logic mw, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] rd, input logic st, input logic fl);
        @(negedge clk);
        drive(rw, rs, mw, alu, rd2, rd, st, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        //            rw    rs    mw    alu           rd2           rd     st    fl    we    addr   wd            chk_wd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0,        5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  32'h1234_5678, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0010, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        5'd3,  1'b0, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'hA5A5_A5A5, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0104, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        5'd9,  1'b0, 1'b0, 1'b1, 5'd9,  32'hA5A5_A5A5, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0,        5'd10, 1'b0, 1'b0, 1'b1, 5'd10, 32'hA5A5_A5A5, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0055, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0020, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1111, 32'h0,        5'd4,  1'b0, 1'b0, 1'b1, 5'd4,  32'h0000_1111, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5'd6,  1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_1111, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_3333, 32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_1111, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0,        5'd11, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0BAD_F00D, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_4444, 32'h0,        5'd12, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0000_5555, 32'h0,        5'd13, 1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_5555, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_addr", {27'd0, addr_3}, 32'd0);
        chk("reset_wd", wd_3, 32'd0);
        chk("reset_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("reset_mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rw, vecs[i].rs, vecs[i].mw, vecs[i].alu, vecs[i].rd2, vecs[i].rd,
                  vecs[i].stall, vecs[i].flush);
            chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_fwd", i), {31'd0, fwd_valid}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_addr", i), {27'd0, addr_3}, {27'd0, vecs[i].e_addr});
            if (vecs[i].chk_wd) begin
                chk($sformatf("v%0d_wd", i), wd_3, vecs[i].e_wd);
            end
            chk($sformatf("v%0d_mis", i), {31'd0, misaligned}, 32'd0);
        end

        // Misaligned store must not touch word 8 and must set the sticky flag.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        chk("mis_store_flag", {31'd0, misaligned}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd14, 1'b0, 1'b0);
        chk("mis_store_word8", wd_3, 32'h0BAD_F00D);
        chk("mis_store_flag_held", {31'd0, misaligned}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0022, 32'h0, 5'd15, 1'b0, 1'b0);
        chk("mis_load_wd", wd_3, 32'd0);
        chk("mis_load_we", {31'd0, we}, 32'd1);
        chk("mis_load_addr", {27'd0, addr_3}, 32'd15);
        chk("mis_load_flag", {31'd0, misaligned}, 32'd1);

        // Mid-stream asynchronous reset clears outputs without a clock edge.
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_7777, 32'h0, 5'd5, 1'b0, 1'b0);
        chk("pre_rst_we", {31'd0, we}, 32'd1);
        chk("pre_rst_addr", {27'd0, addr_3}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, we}, 32'd0);
        chk("async_rst_addr", {27'd0, addr_3}, 32'd0);
        chk("async_rst_wd", wd_3, 32'd0);
        chk("async_rst_mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_8888, 32'h0, 5'd2, 1'b0, 1'b0);
        chk("post_rst_wd", wd_3, 32'h0000_8888);
        chk("post_rst_addr", {27'd0, addr_3}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_wb.md
Name: rv32i_mem_wb

Overview:
- Memory-access and writeback stage of the rv32i pipeline, directly downstream of the decode/execute/memory `top` block.
- Consumes the M-stage bundle regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM.
- Performs word load/store against a local data memory and registers the result into a MEM/WB pipeline register.
- Drives the register-file write port (addr_3, wd_3, we) that feeds back into `top`, plus a W-stage forwarding tap.

Parameters:
- ADW, 5, register address width (matches `top`).
- DMEM_DEPTH, 64, data memory depth in 32-bit words; power of two, at least 4.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous, active-low.
- regwriteM  in  1  M-stage register-write enable.
- resultsrcM  in  1  M-stage result select; 0 = ALU result, 1 = load data.
- memwriteM  in  1  M-stage store enable.
- aluresultM  in  DPW  M-stage ALU result, used as the byte address.
- Rd2M  in  DPW  M-stage store data.
- RdM  in  ADW  M-stage destination register.
- stallW  in  1  hold the MEM/WB register and suppress the store.
- flushW  in  1  bubble the MEM/WB register.
- addr_3  out  ADW  register-file write address.
- wd_3  out  DPW  register-file write data.
- we  out  1  register-file write enable.
- fwd_valid  out  1  a W-stage result is available for forwarding (equals we).
- misaligned  out  1  sticky misaligned-access flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - regwriteW, resultsrcW, RdW, aluresultW and readdataW clear to 0.
  - misaligned clears to 0.
  - Outputs therefore reset to addr_3=0, wd_3=0, we=0, fwd_valid=0.
  - DMEM contents are not reset (undefined); no store occurs while rst_n is low.
- Address mapping:
  - Word index = aluresultM[$clog2(DMEM_DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*DMEM_DEPTH.
  - Misaligned when aluresultM[1:0] != 0.
- Store:
  - On posedge clk, the memory word is written with Rd2M when memwriteM=1, the address is aligned, stallW=0 and rst_n=1.
  - Misaligned store: no write; misaligned sets.
- Load:
  - Combinational read of the addressed word in the M stage.
  - Misaligned load returns 0 and sets misaligned when resultsrcM=1.
- MEM/WB register (posedge):
  - flushW=1: regwriteW <= 0, resultsrcW <= 0, RdW <= 0. flushW wins over stallW.
  - Else stallW=1: hold all W fields.
  - Else capture regwriteM, resultsrcM, aluresultM, load data and RdM.
- Writeback (combinational from W):
  - wd_3 = resultsrcW ? readdataW : aluresultW.
  - addr_3 = RdW.
  - we = regwriteW && (RdW != 0). A write to x0 is never asserted.
- Latency:
  - M-stage inputs appear on addr_3/wd_3/we exactly 1 clk later.
  - A store followed by a load to the same address on the next cycle returns the new data, because the write is synchronous and the read is combinational.
- Same-cycle store and load cannot occur (an instruction is one or the other). memwriteM together with regwriteM is passed through as given; no checking.
- misaligned stays 1 until reset.

Optional Feature:
- RV32I_MEMWB_PERF_EN defined:
  - Adds outputs load_cnt, store_cnt and misalign_cnt, each 16 bits.
  - Each counter increments on a committed load, committed store or misaligned event respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
  - Counting is suppressed when stallW=1 or flushW=1.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

Decomposition:
- rv32i_pkg holds:
  - DPW.
  - a typedef memwb_t struct {regwrite, resultsrc, aluresult, readdata, rd}.
  - the constant RES_ALU=0 / RES_MEM=1.
- One sub-module, rv32i_dmem: single-port, word-wide, sync write, async read, parameterised by DMEM_DEPTH.
- The MEM/WB register and writeback mux live in rv32i_mem_wb.

Test Plan:
- Reset mid-stream: drive regwriteM=1, RdM=5, then pulse rst_n low between edges -> we=0, addr_3=0, wd_3=0 immediately; misaligned=0.
- ALU writeback: regwriteM=1, resultsrcM=0, aluresultM=32'h1234_5678, RdM=7 -> next clk: we=1, addr_3=7, wd_3=32'h1234_5678.
- Store then load: store Rd2M=32'hDEAD_BEEF at address 0x10; next cycle load from 0x10 with RdM=3 -> next clk: wd_3=32'hDEAD_BEEF, addr_3=3, we=1.
- Wrap and x0:
  - Store 32'hA5A5_A5A5 at address 0x104 (DEPTH=64); load from 0x04 -> wd_3=32'hA5A5_A5A5.
  - regwriteM=1 with RdM=0 -> we=0.
- Misaligned: store to 0x22 -> memory word 8 unchanged and misaligned=1, held for the rest of the test; a misaligned load returns wd_3=0.
- Stall/flush:
  - stallW=1 for 2 cycles while the inputs change -> addr_3/wd_3 hold and a concurrent store is suppressed.
  - stallW=1 with flushW=1 -> we=0 the next cycle.
